// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl -- parametrised pipeline hazard controller.
//
// Turns per-stage stall requests, a multi-cycle data-memory wait handshake and
// a flush/redirect request into per-stage stall and bubble enables plus a
// registered redirect PC. Stage 0 is IF, stage STAGES-1 is WB.
//
// Optional build macro: PIPE_CTRL_PERF_EN
//   defined   -> stall_cycles_o counts cycles in which IF is held (not counting
//                flush cycles), wrapping at 2^32, cleared by rst.
//   undefined -> no counter logic; stall_cycles_o is tied to zero.
//
// Ports:
//   clk            clock, all state on rising edge
//   rst            synchronous reset, active-high
//   stall_req_i    [STAGES] bit k: stage k cannot advance this cycle
//   mem_req_i      memory access valid in MEM_STAGE
//   mem_ack_i      memory access completes this cycle
//   flush_req_i    redirect request (branch mispredict / exception)
//   flush_pc_i     [PC_W] redirect target, sampled with flush_req_i
//   stall_o        [STAGES] bit k: hold stage k register
//   bubble_o       [STAGES] bit k: load NOP into stage k register
//   flush_o        one-cycle redirect pulse to pc_reg
//   new_pc_o       [PC_W] redirect target, valid while flush_o
//   mem_busy_o     memory FSM is in WAIT
//   timeout_o      one-cycle pulse, memory access abandoned
//   stall_cycles_o [32] stall cycle count (see macro above)
// -----------------------------------------------------------------------------
module pipe_ctrl #(
  parameter int STAGES       = 5,
  parameter int MEM_STAGE    = 3,
  parameter int MEM_WAIT_MAX = 16,
  parameter int PC_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STAGES-1:0] stall_req_i,
  input  logic              mem_req_i,
  input  logic              mem_ack_i,
  input  logic              flush_req_i,
  input  logic [PC_W-1:0]   flush_pc_i,
  output logic [STAGES-1:0] stall_o,
  output logic [STAGES-1:0] bubble_o,
  output logic              flush_o,
  output logic [PC_W-1:0]   new_pc_o,
  output logic              mem_busy_o,
  output logic              timeout_o,
  output logic [31:0]       stall_cycles_o
);

  localparam int               CNT_W   = $clog2(MEM_WAIT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_WAIT_MAX);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              flush_q;
  logic [PC_W-1:0]   new_pc_q;
  logic              timeout_q;

  logic              mem_stall;
  logic [STAGES-1:0] req;
  logic [STAGES-1:0] stall_raw;
  logic [STAGES-1:0] bubble_raw;

  // The memory stage holds while an access is outstanding, but a WAIT that has
  // already used its full budget releases in the same cycle it times out.
  assign mem_stall = ((state == S_IDLE) && mem_req_i && !mem_ack_i) ||
                     ((state == S_WAIT) && !mem_ack_i && (cnt < CNT_MAX));

  // A stall at stage k must also hold every upstream stage, so stall_raw is a
  // suffix-OR of the request vector; a bubble is inserted where a held stage
  // feeds a stage that is free to advance.
  always_comb begin
    logic acc;
    // NOTE: every variable assigned in always_comb gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    acc                 = 1'b0;
    req                 = stall_req_i;
    req[MEM_STAGE]      = stall_req_i[MEM_STAGE] | mem_stall;
    stall_raw           = '0;
    bubble_raw          = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      acc          = acc | req[k];
      stall_raw[k] = acc;
    end
    for (int k = 1; k < STAGES; k++) begin
      bubble_raw[k] = stall_raw[k-1] & ~stall_raw[k];
    end
  end

  // During the redirect cycle nothing is held and every in-flight stage except
  // IF (reloaded from new_pc_o) and WB (already committed) is squashed.
  always_comb begin
    stall_o  = stall_raw;
    bubble_o = bubble_raw;
    if (flush_q) begin
      stall_o  = '0;
      bubble_o = '0;
      for (int k = 1; k <= STAGES - 2; k++) begin
        bubble_o[k] = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      flush_q   <= 1'b0;
      new_pc_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      flush_q   <= flush_req_i;
      timeout_q <= 1'b0;
      if (flush_req_i) begin
        new_pc_q <= flush_pc_i;
      end
      // A flush abandons any outstanding access; an ack arriving with it is
      // still honoured this cycle through mem_stall.
      if (flush_req_i) begin
        state <= S_IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (mem_req_i && !mem_ack_i) begin
              state <= S_WAIT;
              cnt   <= CNT_W'(1);
            end
          end
          S_WAIT: begin
            if (mem_ack_i) begin
              state <= S_IDLE;
              cnt   <= '0;
            end else if (cnt < CNT_MAX) begin
              cnt <= cnt + 1'b1;
            end else begin
              state     <= S_IDLE;
              cnt       <= '0;
              timeout_q <= 1'b1;
            end
          end
          default: begin
            state <= S_IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign flush_o    = flush_q;
  assign new_pc_o   = new_pc_q;
  assign timeout_o  = timeout_q;
  assign mem_busy_o = (state == S_WAIT);

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_q <= '0;
    end else if (stall_o[0] && !flush_q) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign stall_cycles_o = perf_q;
`else
  assign stall_cycles_o = '0;
`endif

endmodule
